// File: rtl/conv_sched_if.sv
// Handshake and control bus between the conv scheduler, the frame-level control and the MAC datapath.
// The scheduler side uses the master modport. The environment side uses the slave modport.
interface conv_sched_if #(
  parameter int NUM_LAYERS = 5,
  parameter int POSITIONS  = 9,
  parameter int OUT_CH     = 64,
  parameter int IN_CH      = 64,
  parameter int W_ADDR_W   = 18,
  parameter int B_ADDR_W   = 16,
  parameter int O_ADDR_W   = 10
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int PW = (POSITIONS  > 1) ? $clog2(POSITIONS)  : 1;
  localparam int KW = (OUT_CH     > 1) ? $clog2(OUT_CH)     : 1;
  localparam int CW = (IN_CH      > 1) ? $clog2(IN_CH)      : 1;

  logic                start;
  logic                abort;
  logic                mac_ready;
  logic [W_ADDR_W-1:0] weight_addr;
  logic [B_ADDR_W-1:0] bias_addr;
  logic [O_ADDR_W-1:0] out_addr;
  logic [LW-1:0]       layer_idx;
  logic [PW-1:0]       pos_idx;
  logic [KW-1:0]       kernel_idx;
  logic [CW-1:0]       ch_idx;
  logic [3:0]          tap_idx;
  logic                mac_clr;
  logic                mac_en;
  logic                bias_en;
  logic                wb_en;
  logic                busy;
  logic                done;

  modport master (
    input  start, abort, mac_ready,
    output weight_addr, bias_addr, out_addr, layer_idx, pos_idx, kernel_idx, ch_idx, tap_idx,
           mac_clr, mac_en, bias_en, wb_en, busy, done
  );

  modport slave (
    output start, abort, mac_ready,
    input  weight_addr, bias_addr, out_addr, layer_idx, pos_idx, kernel_idx, ch_idx, tap_idx,
           mac_clr, mac_en, bias_en, wb_en, busy, done
  );
endinterface

// File: rtl/conv_scheduler.sv
// Sequencing controller for the shared Conv2D MAC datapath.
// It walks layer > pos > kernel > ch > tap and issues ROM addresses and MAC strobes aligned to a 1-cycle ROM latency.
module conv_scheduler #(
  parameter int NUM_LAYERS = 5,
  parameter int POSITIONS  = 9,
  parameter int OUT_CH     = 64,
  parameter int IN_CH      = 64,
  parameter int W_ADDR_W   = 18,
  parameter int B_ADDR_W   = 16,
  parameter int O_ADDR_W   = 10
) (
  input logic         clk,
  input logic         rst,
  conv_sched_if.master bus
);
  localparam int K  = IN_CH * 9;
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int PW = (POSITIONS  > 1) ? $clog2(POSITIONS)  : 1;
  localparam int KW = (OUT_CH     > 1) ? $clog2(OUT_CH)     : 1;
  localparam int CW = (IN_CH      > 1) ? $clog2(IN_CH)      : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_TAP, S_BADDR, S_BADD, S_WB, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [KW-1:0] kernel_q, kernel_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [3:0]    tap_q, tap_d;
  logic          issue;
  logic          mac_en_q;

  logic last_tap, last_ch, last_kernel, last_pos, last_layer;
  assign last_tap    = (tap_q == 4'd8);
  assign last_ch     = (ch_q == CW'(IN_CH - 1));
  assign last_kernel = (kernel_q == KW'(OUT_CH - 1));
  assign last_pos    = (pos_q == PW'(POSITIONS - 1));
  assign last_layer  = (layer_q == LW'(NUM_LAYERS - 1));

  // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    pos_d    = pos_q;
    kernel_d = kernel_q;
    ch_d     = ch_q;
    tap_d    = tap_q;
    issue    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CLR;
      S_CLR:   state_d = S_TAP;
      S_TAP: begin
        if (bus.mac_ready) begin
          issue = 1'b1;
          if (last_tap) begin
            tap_d = '0;
            if (last_ch) begin
              ch_d    = '0;
              state_d = S_BADDR;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
      end
      S_BADDR: state_d = S_BADD;
      S_BADD:  state_d = S_WB;
      S_WB: begin
        state_d = S_CLR;
        if (last_kernel) begin
          kernel_d = '0;
          if (last_pos) begin
            pos_d = '0;
            if (last_layer) begin
              layer_d = '0;
              state_d = S_DONE;
            end else begin
              layer_d = layer_q + 1'b1;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          kernel_d = kernel_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything; zeroed indices make the next start begin at layer 0.
    if (bus.abort) begin
      state_d  = S_IDLE;
      layer_d  = '0;
      pos_d    = '0;
      kernel_d = '0;
      ch_d     = '0;
      tap_d    = '0;
      issue    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      layer_q  <= '0;
      pos_q    <= '0;
      kernel_q <= '0;
      ch_q     <= '0;
      tap_q    <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      pos_q    <= pos_d;
      kernel_q <= kernel_d;
      ch_q     <= ch_d;
      tap_q    <= tap_d;
      mac_en_q <= issue;
    end
  end

  assign bus.weight_addr = W_ADDR_W'((32'(layer_q) * 32'(OUT_CH) + 32'(kernel_q)) * 32'(K)
                                     + 32'(ch_q) * 32'd9 + 32'(tap_q));
  assign bus.bias_addr   = B_ADDR_W'(32'(layer_q) * 32'(OUT_CH) + 32'(kernel_q));
  assign bus.out_addr    = O_ADDR_W'(32'(pos_q) * 32'(OUT_CH) + 32'(kernel_q));
  assign bus.layer_idx   = layer_q;
  assign bus.pos_idx     = pos_q;
  assign bus.kernel_idx  = kernel_q;
  assign bus.ch_idx      = ch_q;
  assign bus.tap_idx     = tap_q;
  assign bus.mac_clr     = (state_q == S_CLR);
  assign bus.mac_en      = mac_en_q;
  assign bus.bias_en     = (state_q == S_BADD);
  assign bus.wb_en       = (state_q == S_WB);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_conv_scheduler.sv
// Directed testbench for conv_scheduler on a small 2x2x2x1 configuration.
// A negedge monitor records strobes and addresses, and each test task compares them with hand-derived values.
module tb_conv_scheduler;
  localparam int NL      = 2;
  localparam int NP      = 2;
  localparam int OC      = 2;
  localparam int IC      = 1;
  localparam int K       = IC * 9;
  localparam int KERNELS = NL * NP * OC;
  localparam int PASS    = KERNELS * (K + 4);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_sched_if #(.NUM_LAYERS(NL), .POSITIONS(NP), .OUT_CH(OC), .IN_CH(IC),
                  .W_ADDR_W(18), .B_ADDR_W(16), .O_ADDR_W(10)) bus ();

  conv_scheduler #(.NUM_LAYERS(NL), .POSITIONS(NP), .OUT_CH(OC), .IN_CH(IC),
                   .W_ADDR_W(18), .B_ADDR_W(16), .O_ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_clr, n_en, n_bias, n_wb, n_done, n_overlap, clr_cyc, done_cyc;
  logic [17:0] prev_waddr = '0;
  int wq[$];
  int bq[$];
  int oq[$];

  // mac_en in cycle t belongs to the weight address presented in cycle t-1.
  always @(negedge clk) begin
    cyc++;
    if (bus.mac_clr) begin
      if (n_clr == 0) clr_cyc = cyc;
      n_clr++;
    end
    if (bus.mac_en) begin
      n_en++;
      wq.push_back(int'(prev_waddr));
    end
    if (bus.bias_en) begin
      n_bias++;
      bq.push_back(int'(bus.bias_addr));
    end
    if (bus.wb_en) begin
      n_wb++;
      oq.push_back(int'(bus.out_addr));
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.mac_clr && bus.mac_en) n_overlap++;
    prev_waddr = bus.weight_addr;
  end

  function automatic int exp_waddr(int i);
    int g = i / K;
    return (g / (NP * OC)) * OC * K + (g % OC) * K + (i % K);
  endfunction

  function automatic int exp_out(int g);
    return ((g / OC) % NP) * OC + (g % OC);
  endfunction

  function automatic int exp_bias(int g);
    return (g / (NP * OC)) * OC + (g % OC);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    n_clr = 0; n_en = 0; n_bias = 0; n_wb = 0; n_done = 0; n_overlap = 0;
    clr_cyc = 0; done_cyc = 0;
    wq.delete(); bq.delete(); oq.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (n_done > 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mac_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({bus.mac_clr, bus.mac_en, bus.bias_en, bus.wb_en, bus.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 00000",
               {bus.mac_clr, bus.mac_en, bus.bias_en, bus.wb_en, bus.done});
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.weight_addr !== 18'd0 || bus.bias_addr !== 16'd0 || bus.out_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got w=%0d b=%0d o=%0d want 0 0 0",
               bus.weight_addr, bus.bias_addr, bus.out_addr);
    end
    n_checks++;
    if ({bus.layer_idx, bus.pos_idx, bus.kernel_idx, bus.ch_idx, bus.tap_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_idx: got l=%0d p=%0d k=%0d c=%0d t=%0d want all 0",
               bus.layer_idx, bus.pos_idx, bus.kernel_idx, bus.ch_idx, bus.tap_idx);
    end
  endtask

  task automatic test_nominal();
    bit ok;
    mon_clear();
    pulse_start();
    n_checks++;
    if (bus.mac_clr !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_clr_entry: got clr=%b busy=%b want 1 1", bus.mac_clr, bus.busy);
    end
    run_until_done(PASS + 50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL nom_timeout: got no done within %0d cycles want done", PASS + 50);
    end
    n_checks++;
    if (n_clr !== 8 || n_en !== 72 || n_bias !== 8 || n_wb !== 8 || n_done !== 1) begin
      n_fail++;
      $display("FAIL nom_counts: got clr=%0d en=%0d bias=%0d wb=%0d done=%0d want 8 72 8 8 1",
               n_clr, n_en, n_bias, n_wb, n_done);
    end
    n_checks++;
    if (done_cyc - clr_cyc !== PASS) begin
      n_fail++;
      $display("FAIL nom_length: got %0d want %0d", done_cyc - clr_cyc, PASS);
    end
    n_checks++;
    if (n_overlap !== 0) begin
      n_fail++;
      $display("FAIL nom_clr_en_overlap: got %0d want 0", n_overlap);
    end
    for (int i = 0; i < wq.size() && i < 72; i++) begin
      n_checks++;
      if (wq[i] !== exp_waddr(i)) begin
        n_fail++;
        $display("FAIL nom_waddr[%0d]: got %0d want %0d", i, wq[i], exp_waddr(i));
      end
    end
    for (int g = 0; g < oq.size() && g < KERNELS; g++) begin
      n_checks++;
      if (oq[g] !== exp_out(g) || bq[g] !== exp_bias(g)) begin
        n_fail++;
        $display("FAIL nom_out_bias[%0d]: got o=%0d b=%0d want o=%0d b=%0d",
                 g, oq[g], bq[g], exp_out(g), exp_bias(g));
      end
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_idle_after: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit found = 1'b0;
    mon_clear();
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (bus.weight_addr == 18'd4) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL stall_reach_tap4: got no weight_addr 4 want it within 50 cycles");
    end
    bus.mac_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      if (s == 2) bus.mac_ready = 1'b1;
      n_checks++;
      if (bus.weight_addr !== 18'd4 || bus.mac_en !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got w=%0d en=%b want w=4 en=0", s, bus.weight_addr, bus.mac_en);
      end
    end
    step();
    n_checks++;
    if (bus.mac_en !== 1'b1 || bus.weight_addr !== 18'd5) begin
      n_fail++;
      $display("FAIL stall_resume: got w=%0d en=%b want w=5 en=1", bus.weight_addr, bus.mac_en);
    end
    run_until_done(PASS + 50, ok);
    n_checks++;
    if (!ok || n_en !== 72 || n_done !== 1) begin
      n_fail++;
      $display("FAIL stall_counts: got ok=%b en=%0d done=%0d want 1 72 1", ok, n_en, n_done);
    end
    n_checks++;
    if (done_cyc - clr_cyc !== PASS + 3) begin
      n_fail++;
      $display("FAIL stall_length: got %0d want %0d", done_cyc - clr_cyc, PASS + 3);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit found = 1'b0;
    int snap;
    mon_clear();
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (bus.mac_clr && bus.kernel_idx == 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_reach_k1: got no second-kernel clear want one within 50 cycles");
    end
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || {bus.mac_clr, bus.mac_en, bus.bias_en, bus.wb_en, bus.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b strobes=%b want 0 00000", bus.busy,
               {bus.mac_clr, bus.mac_en, bus.bias_en, bus.wb_en, bus.done});
    end
    snap = n_clr + n_en + n_bias + n_wb;
    repeat (20) step();
    n_checks++;
    if (n_clr + n_en + n_bias + n_wb !== snap || n_done !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got strobes=%0d done=%0d want %0d 0",
               n_clr + n_en + n_bias + n_wb, n_done, snap);
    end
    mon_clear();
    pulse_start();
    n_checks++;
    if (bus.mac_clr !== 1'b1 || bus.weight_addr !== 18'd0 || bus.kernel_idx !== 1'b0 || bus.layer_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_restart: got clr=%b w=%0d k=%0d l=%0d want 1 0 0 0",
               bus.mac_clr, bus.weight_addr, bus.kernel_idx, bus.layer_idx);
    end
    run_until_done(PASS + 50, ok);
    n_checks++;
    if (!ok || n_en !== 72 || done_cyc - clr_cyc !== PASS) begin
      n_fail++;
      $display("FAIL abort_rerun: got ok=%b en=%0d len=%0d want 1 72 %0d",
               ok, n_en, done_cyc - clr_cyc, PASS);
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    bit found = 1'b0;
    mon_clear();
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      if (bus.mac_clr && bus.pos_idx == 1'b1 && bus.kernel_idx == 1'b0 && bus.layer_idx == 1'b0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL busy_reach_p1: got no clear at pos 1 want one within 60 cycles");
    end
    pulse_start();
    n_checks++;
    if (bus.mac_clr !== 1'b0 || bus.busy !== 1'b1 || bus.pos_idx !== 1'b1 ||
        bus.kernel_idx !== 1'b0 || bus.tap_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL busy_start_clr: got clr=%b busy=%b p=%0d k=%0d t=%0d want 0 1 1 0 0",
               bus.mac_clr, bus.busy, bus.pos_idx, bus.kernel_idx, bus.tap_idx);
    end
    repeat (2) step();
    pulse_start();
    n_checks++;
    if (bus.tap_idx !== 4'd3 || bus.pos_idx !== 1'b1 || bus.weight_addr !== 18'd3) begin
      n_fail++;
      $display("FAIL busy_start_tap: got t=%0d p=%0d w=%0d want 3 1 3",
               bus.tap_idx, bus.pos_idx, bus.weight_addr);
    end
    run_until_done(PASS + 50, ok);
    repeat (10) step();
    n_checks++;
    if (!ok || n_done !== 1 || n_clr !== 8 || n_en !== 72 || done_cyc - clr_cyc !== PASS) begin
      n_fail++;
      $display("FAIL busy_single_pass: got ok=%b done=%0d clr=%0d en=%0d len=%0d want 1 1 8 72 %0d",
               ok, n_done, n_clr, n_en, done_cyc - clr_cyc, PASS);
    end
  endtask

  task automatic test_abort_start_idle();
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mac_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start_idle: got busy=%b clr=%b want 0 0", bus.busy, bus.mac_clr);
    end
    step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mac_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start_idle_hold: got busy=%b en=%b want 0 0", bus.busy, bus.mac_en);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_abort();
    test_start_busy();
    test_abort_start_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
